// File: rtl/reg_dump_uart_pkg.sv
// Shared definitions for the register dump UART.
// Holds the FSM state encoding, the default frame header byte and the frame geometry
// (frame length, bytes per register word, register count).
package reg_dump_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StAdrs,
        StLatch,
        StSend,
        StWait,
        StFin
    } state_e;

    localparam logic [7:0]  DefaultHeader = 8'hA5;
    localparam int unsigned NumRegs       = 32;
    localparam int unsigned BytesPerWord  = 4;
    // Header byte plus every register word.
    localparam int unsigned FrameBytes    = 1 + NumRegs * BytesPerWord;
    localparam logic [4:0]  LastIndex     = 5'(NumRegs - 1);

endpackage

// File: rtl/reg_dump_uart_if.sv
// Register-file debug read port.
//   reg_dbg_adrs : read address, driven by the dumper (master)
//   reg_dbg_q    : read data for reg_dbg_adrs, driven by the register file (slave)
interface reg_dump_uart_if;

    logic [4:0]  reg_dbg_adrs;
    logic [31:0] reg_dbg_q;

    modport master (
        output reg_dbg_adrs,
        input  reg_dbg_q
    );

    modport slave (
        input  reg_dbg_adrs,
        output reg_dbg_q
    );

endinterface

// File: rtl/reg_dump_uart_uart_tx.sv
// 8N1 UART serializer.
//   clk_cpu : clock           reset : async active-low reset
//   data    : byte to send    valid : byte offered
//   ready   : can accept      txd   : serial line, idle high
// A byte is taken on valid && ready; ready drops the next cycle and returns high in the
// final cycle of the stop bit, so a byte offered then starts with no idle gap.
// CLKS_PER_BIT must be at least 2.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastClk = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] ReadyClk = CntW'(CLKS_PER_BIT - 2);

    logic [8:0]      shift_q;   // bits still to go out after the current one
    logic [3:0]      bit_q;     // number of bits left after the current one
    logic [CntW-1:0] clk_q;
    logic            active_q;
    logic            ready_q;
    logic            txd_q;

    assign ready = ready_q;
    assign txd   = txd_q;

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            bit_q    <= '0;
            clk_q    <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            txd_q    <= 1'b1;
        end else if (valid && ready_q) begin
            txd_q    <= 1'b0;
            shift_q  <= {1'b1, data};
            bit_q    <= 4'd9;
            clk_q    <= '0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
        end else if (active_q) begin
            if (clk_q == LastClk) begin
                clk_q <= '0;
                if (bit_q == 4'd0) begin
                    active_q <= 1'b0;
                end else begin
                    txd_q   <= shift_q[0];
                    shift_q <= {1'b0, shift_q[8:1]};
                    bit_q   <= bit_q - 4'd1;
                end
            end else begin
                clk_q <= clk_q + 1'b1;
                // Reopen one cycle early so the next start bit follows the stop bit directly.
                if (bit_q == 4'd0 && clk_q == ReadyClk) begin
                    ready_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_dump_uart.sv
// Register file dump over UART.
//   clk_cpu : clock                   reset : async active-low reset
//   start   : one-cycle dump request  dbg   : register-file debug read port (master)
//   txd     : UART out, 8N1           busy  : frame in progress
//   done    : one-cycle pulse after the last stop bit
// Frame: HEADER, then registers 0..31, each most significant byte first.
module reg_dump_uart
    import reg_dump_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = DefaultHeader
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic            start,
    reg_dump_uart_if.master dbg,
    output logic            txd,
    output logic            busy,
    output logic            done
);

    state_e      state_q;
    logic [4:0]  index_q;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic [4:0]  adrs_q;
    logic        busy_q;
    logic        done_q;
    logic        first_q;   // next WAIT follows the header byte

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    assign dbg.reg_dbg_adrs = adrs_q;
    assign busy             = busy_q;
    assign done             = done_q;

    // Decoded from the state register only, so the offer is glitch-free.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = word_q[{cnt_q, 3'b000} +: 8];
        if (state_q == StHdr) begin
            tx_valid = 1'b1;
            tx_data  = HEADER;
        end else if (state_q == StSend) begin
            tx_valid = 1'b1;
        end
    end

    // HDR and SEND hold their byte until the serializer takes it, which lets the next
    // word be fetched while the current byte is still on the line.
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            index_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            adrs_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= StHdr;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                    end
                end
                StHdr: begin
                    if (tx_ready) state_q <= StWait;
                end
                StAdrs: begin
                    adrs_q  <= index_q;
                    state_q <= StLatch;
                end
                StLatch: begin
                    word_q  <= dbg.reg_dbg_q;
                    cnt_q   <= 2'(BytesPerWord - 1);
                    state_q <= StSend;
                end
                StSend: begin
                    if (tx_ready) state_q <= StWait;
                end
                StWait: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                        index_q <= '0;
                        state_q <= StAdrs;
                    end else if (cnt_q != 2'd0) begin
                        cnt_q   <= cnt_q - 2'd1;
                        state_q <= StSend;
                    end else if (index_q != LastIndex) begin
                        index_q <= index_q + 5'd1;
                        state_q <= StAdrs;
                    end else if (tx_ready) begin
                        // Serializer is back to ready only once the last stop bit ends.
                        state_q <= StFin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StFin: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_cpu(clk_cpu),
        .reset  (reset),
        .data   (tx_data),
        .valid  (tx_valid),
        .ready  (tx_ready),
        .txd    (txd)
    );

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart with CLKS_PER_BIT=4; register n holds 32'h1000_0000 + n.
// Stimulus pushes expected bytes into exp_q; a UART monitor decodes txd and compares.
module tb_reg_dump_uart;
    import reg_dump_uart_pkg::*;

    localparam int unsigned Cpb      = 4;
    localparam int unsigned ByteCyc  = 10 * Cpb;
    localparam int unsigned FrameCyc = FrameBytes * ByteCyc;

    logic clk;
    logic rst_n;
    logic start;
    logic txd;
    logic busy;
    logic done;

    logic [31:0] regs [32];

    reg_dump_uart_if dbg_if ();
    assign dbg_if.reg_dbg_q = regs[dbg_if.reg_dbg_adrs];

    reg_dump_uart #(
        .CLKS_PER_BIT(Cpb),
        .HEADER      (8'hA5)
    ) dut (
        .clk_cpu(clk),
        .reset  (rst_n),
        .start  (start),
        .dbg    (dbg_if),
        .txd    (txd),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int low_cnt = 0;
    int byte_cnt = 0;
    int byte_start [$];
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (!txd) low_cnt <= low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        exp_q.push_back(8'hA5);
        for (int n = 0; n < 32; n++) begin
            exp_q.push_back(8'h10);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(n));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which done is high.
    task automatic wait_done(input string name, output int at_cyc);
        bit ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < FrameCyc + 500; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // UART monitor: start bit seen at a negedge, then 40 samples, one per cycle.
    initial begin : monitor
        logic [39:0] s;
        logic [7:0]  b;
        bit          aborted;
        bit          ok_t;
        int          st;
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                st = cyc;
                s = '0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = txd;
                end
                if (!aborted) begin
                    ok_t = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
                    for (int k = 1; k <= 8; k++) begin
                        if (s[4*k +: 4] != 4'h0 && s[4*k +: 4] != 4'hF) ok_t = 1'b0;
                        b[k-1] = s[4*k];
                    end
                    byte_start.push_back(st);
                    byte_cnt++;
                    check("bit_timing", 32'(ok_t), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_unexpected: got %0h expected none", b);
                    end else begin
                        check("byte_value", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : stim
        int d0, b0, bc0, done_at, lc0;
        for (int n = 0; n < 32; n++) regs[n] = 32'h1000_0000 + 32'(n);
        rst_n = 1'b0;
        start = 1'b0;

        // Reset state
        #12;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_adrs", 32'(dbg_if.reg_dbg_adrs), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single dump: values, length, busy span, back-to-back timing
        d0 = done_cnt; b0 = busy_cyc; bc0 = byte_cnt;
        push_frame();
        pulse_start();
        wait_done("frame1_done", done_at);
        repeat (5) @(negedge clk);
        check("frame1_bytes", 32'(byte_cnt - bc0), 32'(FrameBytes));
        check("frame1_done_cnt", 32'(done_cnt - d0), 32'd1);
        // HDR issue cycle plus the frame itself
        check("frame1_busy_cyc", 32'(busy_cyc - b0), 32'(FrameCyc + 1));
        if (byte_cnt > bc0)
            check("frame1_span", 32'(done_at - byte_start[bc0]), 32'(FrameCyc));
        check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("adrs_hold", 32'(dbg_if.reg_dbg_adrs), 32'd31);

        // Tearing: register 5 changes right after it has been latched
        bc0 = byte_cnt;
        push_frame();
        pulse_start();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (dbg_if.reg_dbg_adrs == 5'd5) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("tear_adrs5_seen", 32'(seen), 32'd1);
        end
        @(posedge clk); #1 regs[5] = 32'hDEAD_BEEF;
        wait_done("tear_done", done_at);
        regs[5] = 32'h1000_0005;
        repeat (5) @(negedge clk);
        check("tear_bytes", 32'(byte_cnt - bc0), 32'(FrameBytes));
        check("tear_queue_empty", 32'(exp_q.size()), 32'd0);

        // start held high: one frame, then a second accepted in the IDLE after FIN
        d0 = done_cnt; bc0 = byte_cnt;
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        wait_done("held_done1", done_at);
        check("held_fin_busy", 32'(busy), 32'd0);
        push_frame();
        @(negedge clk);
        check("held_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("held_done2", done_at);
        repeat (5) @(negedge clk);
        check("held_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("held_bytes", 32'(byte_cnt - bc0), 32'(2 * FrameBytes));
        check("held_queue_empty", 32'(exp_q.size()), 32'd0);

        // start in the FIN cycle is ignored
        push_frame();
        pulse_start();
        wait_done("fin_done", done_at);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        d0 = done_cnt; b0 = busy_cyc; bc0 = byte_cnt; lc0 = low_cnt;
        repeat (100) @(negedge clk);
        #1;
        check("fin_no_busy", 32'(busy_cyc - b0), 32'd0);
        check("fin_no_bytes", 32'(byte_cnt - bc0), 32'd0);
        check("fin_txd_idle", 32'(low_cnt - lc0), 32'd0);
        check("fin_no_done", 32'(done_cnt - d0), 32'd0);
        check("fin_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during byte 60 aborts the frame; a fresh start gives a full frame
        bc0 = byte_cnt;
        push_frame();
        pulse_start();
        begin
            bit reached = 1'b0;
            for (int i = 0; i < FrameCyc; i++) begin
                @(negedge clk);
                if (byte_cnt - bc0 >= 59) begin
                    reached = 1'b1;
                    break;
                end
            end
            check("rst_mid_reach59", 32'(reached), 32'd1);
        end
        repeat (20) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("rst_mid_txd", 32'(txd), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_adrs", 32'(dbg_if.reg_dbg_adrs), 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        bc0 = byte_cnt;
        push_frame();
        pulse_start();
        wait_done("rst_fresh_done", done_at);
        repeat (5) @(negedge clk);
        check("rst_fresh_bytes", 32'(byte_cnt - bc0), 32'(FrameBytes));
        check("rst_fresh_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
